strb_period_mon: RTL and testbench

Strobe period monitor: the receiving end of the programmable-strobe counter. It watches a one-clock strobe train, measures the clock count between consecutive strobes, and checks each period against a loaded expected value with a tolerance window. It sits beside the SD single-block write path and reports early strobes and missing strobes (timeouts) to the controller.

---
 rtl/strb_period_mon.sv | 172 +++++++++++++++++
 tb/tb_strb_period_mon.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/strb_period_mon.sv
// Strobe period monitor: measures clocks between strobes and flags short periods and timeouts.
// Optional STRB_MON_TOL_EN enables the tolerance window; otherwise the window is exact.
module strb_period_mon #(
    parameter int unsigned dw = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          load_limit,
    input  logic [dw-1:0] exp_period,
    input  logic [dw-1:0] tol,
    input  logic          strb_in,
    input  logic          clr_err,
    output logic          armed,
    output logic [dw-1:0] period,
    output logic          period_vld,
    output logic          short_err,
    output logic          timeout,
    output logic [1:0]    err_sticky
);

    localparam int unsigned DW1 = dw + 1;
    localparam logic [dw-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_MEASURE    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [dw-1:0] r_exp;
    logic [dw-1:0] r_cnt;
    logic [dw-1:0] r_period;
    logic          r_armed;
    logic          r_vld;
    logic          r_short;
    logic          r_timeout;
    logic [1:0]    r_sticky;

    logic [dw-1:0] w_tol;
    logic [dw-1:0] w_exp_nxt;
    logic [dw-1:0] w_cnt_nxt;
    logic [dw-1:0] w_period_nxt;
    logic          w_armed_nxt;
    logic          w_vld_nxt;
    logic          w_short_nxt;
    logic          w_timeout_nxt;
    logic [1:0]    w_sticky_nxt;

    logic [DW1-1:0] w_sum;
    logic [DW1-1:0] w_cnt_inc;
    logic [dw-1:0]  w_hi;
    logic [dw-1:0]  w_lo;
    logic [dw-1:0]  w_inc_sat;

`ifdef STRB_MON_TOL_EN
    logic [dw-1:0] r_tol;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tol <= '0;
        end else if (load_limit) begin
            r_tol <= tol;
        end
    end

    assign w_tol = r_tol;
`else
    logic w_unused_tol;

    assign w_tol        = '0;
    assign w_unused_tol = ^tol;
`endif

    // Acceptance window [lo, hi], clamped at both ends
    assign w_sum     = {1'b0, r_exp} + {1'b0, w_tol};
    assign w_hi      = w_sum[dw] ? CNT_MAX : w_sum[dw-1:0];
    assign w_lo      = (r_exp > w_tol) ? (r_exp - w_tol) : '0;
    assign w_cnt_inc = {1'b0, r_cnt} + DW1'(1);
    assign w_inc_sat = w_cnt_inc[dw] ? CNT_MAX : w_cnt_inc[dw-1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_exp_nxt     = r_exp;
        w_cnt_nxt     = r_cnt;
        w_period_nxt  = r_period;
        w_armed_nxt   = r_armed;
        w_vld_nxt     = 1'b0;
        w_short_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;

        if (load_limit) begin
            w_exp_nxt   = exp_period;
            w_armed_nxt = (exp_period != '0);
            w_cnt_nxt   = '0;
            w_state_nxt = (enable && (exp_period != '0)) ? ST_WAIT_FIRST : ST_IDLE;
        end else if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (r_armed) begin
                        w_state_nxt = ST_WAIT_FIRST;
                    end
                end
                ST_WAIT_FIRST: begin
                    w_cnt_nxt = '0;
                    if (strb_in) begin
                        w_state_nxt = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (strb_in) begin
                        w_period_nxt = w_inc_sat;
                        w_vld_nxt    = 1'b1;
                        w_short_nxt  = (w_cnt_inc < {1'b0, w_lo});
                        w_cnt_nxt    = '0;
                    end else if (r_cnt >= w_hi) begin
                        w_timeout_nxt = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_WAIT_FIRST;
                    end else begin
                        w_cnt_nxt = w_inc_sat;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // A new error in the same cycle as a clear stays set
        w_sticky_nxt = (clr_err ? 2'b00 : r_sticky) | {w_timeout_nxt, w_short_nxt};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_exp     <= '0;
            r_cnt     <= '0;
            r_period  <= '0;
            r_armed   <= 1'b0;
            r_vld     <= 1'b0;
            r_short   <= 1'b0;
            r_timeout <= 1'b0;
            r_sticky  <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_exp     <= w_exp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_armed   <= w_armed_nxt;
            r_vld     <= w_vld_nxt;
            r_short   <= w_short_nxt;
            r_timeout <= w_timeout_nxt;
            r_sticky  <= w_sticky_nxt;
        end
    end

    assign armed      = r_armed;
    assign period     = r_period;
    assign period_vld = r_vld;
    assign short_err  = r_short;
    assign timeout    = r_timeout;
    assign err_sticky = r_sticky;

endmodule

// File: tb/tb_strb_period_mon.sv
// Randomized and directed bench for strb_period_mon against a cycle-count reference model.
module tb_strb_period_mon;

    localparam int unsigned DW   = 16;
    localparam int          VMAX = 65535;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable = 1'b0;
    logic          load_limit = 1'b0;
    logic [DW-1:0] exp_period = '0;
    logic [DW-1:0] tol = '0;
    logic          strb_in = 1'b0;
    logic          clr_err = 1'b0;
    logic          armed;
    logic [DW-1:0] period;
    logic          period_vld;
    logic          short_err;
    logic          timeout;
    logic [1:0]    err_sticky;

    always #5 clk = ~clk;

    strb_period_mon #(.dw(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_limit (load_limit),
        .exp_period (exp_period),
        .tol        (tol),
        .strb_in    (strb_in),
        .clr_err    (clr_err),
        .armed      (armed),
        .period     (period),
        .period_vld (period_vld),
        .short_err  (short_err),
        .timeout    (timeout),
        .err_sticky (err_sticky)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: tracks the clock index of the last strobe, not a counter
    int     m_mode;     // 0 idle, 1 waiting for first strobe, 2 measuring
    int     m_exp, m_tol, m_period;
    bit     m_armed, m_vld, m_short, m_to;
    bit [1:0] m_sticky;
    longint cyc = 0;
    longint m_last = 0;

    function automatic void model_reset();
        m_mode = 0; m_exp = 0; m_tol = 0; m_period = 0;
        m_armed = 0; m_vld = 0; m_short = 0; m_to = 0; m_sticky = 2'b00;
    endfunction

    function automatic void model_step();
        int eff_tol, lo, hi, el;
        cyc++;
`ifdef STRB_MON_TOL_EN
        eff_tol = m_tol;
`else
        eff_tol = 0;
`endif
        lo = (m_exp > eff_tol) ? m_exp - eff_tol : 0;
        hi = (m_exp + eff_tol > VMAX) ? VMAX : m_exp + eff_tol;
        m_vld = 0; m_short = 0; m_to = 0;
        if (load_limit) begin
            m_exp   = int'(exp_period);
            m_tol   = int'(tol);
            m_armed = (exp_period != 0);
            m_mode  = (enable && m_armed) ? 1 : 0;
        end else if (!enable) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (m_armed) m_mode = 1;
        end else if (m_mode == 1) begin
            if (strb_in) begin
                m_mode = 2;
                m_last = cyc;
            end
        end else begin
            el = int'(cyc - m_last);
            if (strb_in) begin
                m_vld    = 1;
                m_period = (el > VMAX) ? VMAX : el;
                m_short  = (el < lo);
                m_last   = cyc;
            end else if (el > hi) begin
                m_to   = 1;
                m_mode = 1;
            end
        end
        m_sticky = (clr_err ? 2'b00 : m_sticky) | {m_to, m_short};
    endfunction

    task automatic check_all();
        chk("armed",      32'(armed),      32'(m_armed));
        chk("period",     32'(period),     32'(m_period));
        chk("period_vld", 32'(period_vld), 32'(m_vld));
        chk("short_err",  32'(short_err),  32'(m_short));
        chk("timeout",    32'(timeout),    32'(m_to));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check_all();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        reset_n = 1'b1;
    endtask

    task automatic load(input int e, input int t);
        load_limit = 1'b1;
        exp_period = DW'(e);
        tol        = DW'(t);
        cycle(1);
        load_limit = 1'b0;
    endtask

    // Strobe `gap` clocks after the previous strobe
    task automatic strobe_after(input int gap);
        strb_in = 1'b0;
        if (gap > 1) cycle(gap - 1);
        strb_in = 1'b1;
        cycle(1);
        strb_in = 1'b0;
    endtask

    initial begin
        int waited;
        int p_strb;
        do_reset();
        enable = 1'b1;

        // Exact period, no tolerance
        load(5, 0);
        strobe_after(1);
        repeat (3) begin
            strobe_after(5);
            chk("t1_vld", 32'(period_vld), 32'd1);
            chk("t1_period", 32'(period), 32'd5);
        end
        chk("t1_sticky", 32'(err_sticky), 32'd0);

        // Tolerance window, then a short period
        load(10, 2);
        strobe_after(1);
        strobe_after(8);
        strobe_after(12);
        strobe_after(7);
        chk("t2_short", 32'(short_err), 32'd1);
        chk("t2_period", 32'(period), 32'd7);
        chk("t2_sticky0", 32'(err_sticky[0]), 32'd1);

        // Timeout after silence, then clear
        clr_err = 1'b1;
        load(10, 2);
        clr_err = 1'b0;
        strobe_after(1);
        waited = 0;
        while (!timeout && waited < 100) begin
            cycle(1);
            waited++;
        end
`ifdef STRB_MON_TOL_EN
        chk("t3_to_delay", 32'(waited), 32'd13);
`else
        chk("t3_to_delay", 32'(waited), 32'd11);
`endif
        chk("t3_sticky1", 32'(err_sticky[1]), 32'd1);
        cycle(3);
        chk("t3_no_period", 32'(period_vld), 32'd0);
        clr_err = 1'b1;
        cycle(1);
        clr_err = 1'b0;
        chk("t3_cleared", 32'(err_sticky), 32'd0);

        // Back-to-back strobes, then disarm
        load(1, 0);
        strb_in = 1'b1;
        cycle(2);
        repeat (4) begin
            cycle(1);
            chk("t4_period", 32'(period), 32'd1);
            chk("t4_short", 32'(short_err), 32'd0);
        end
        strb_in = 1'b0;
        load(0, 0);
        chk("t4_armed", 32'(armed), 32'd0);
        strb_in = 1'b1;
        cycle(5);
        strb_in = 1'b0;
        chk("t4_ignored", 32'(period_vld), 32'd0);

        // Load coincident with strobe, then reset mid-count
        load(10, 2);
        strobe_after(1);
        cycle(4);
        strb_in = 1'b1;
        load(10, 2);
        strb_in = 1'b0;
        chk("t5_load_strb", 32'(period_vld), 32'd0);
        strobe_after(1);
        strobe_after(6);
        cycle(3);
        do_reset();
        chk("t5_rst_period", 32'(period), 32'd0);
        chk("t5_rst_armed", 32'(armed), 32'd0);

        // Tolerance option
        load(10, 5);
        strobe_after(1);
        strobe_after(9);
`ifdef STRB_MON_TOL_EN
        chk("t6_tol_short", 32'(short_err), 32'd0);
`else
        chk("t6_tol_short", 32'(short_err), 32'd1);
`endif

        // Random traffic
        p_strb = 20;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) p_strb = $urandom_range(3, 45);
            load_limit = ($urandom_range(0, 39) == 0);
            exp_period = ($urandom_range(0, 9) == 0) ? DW'(0) : DW'($urandom_range(1, 20));
            tol        = DW'($urandom_range(0, 6));
            enable     = ($urandom_range(0, 49) != 0);
            strb_in    = ($urandom_range(0, 99) < p_strb);
            clr_err    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
